// File: rtl/immext_pipe.sv
// Registered immediate generator for decode: extracts/extends the immediate and
// buffers it with its tag in a 2-entry FIFO behind a valid/ready handshake.
module immext_pipe #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  input  logic [2:0]       in_imm_src,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_imm,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_illegal,
  output logic [CNT_W-1:0] illegal_cnt
);

  localparam logic [2:0] IMM_TYPE_I  = 3'd0;
  localparam logic [2:0] IMM_TYPE_S  = 3'd1;
  localparam logic [2:0] IMM_TYPE_B  = 3'd2;
  localparam logic [2:0] IMM_TYPE_J  = 3'd3;
  localparam logic [2:0] IMM_TYPE_U  = 3'd4;
  localparam logic [2:0] IMM_TYPE_Z  = 3'd5;
  localparam logic [2:0] IMM_TYPE_SH = 3'd6;

  logic [XLEN-1:0]  dec_imm;
  logic             dec_illegal;
  logic             accept;
  logic             emit;

  logic [XLEN-1:0]  imm_q [2];
  logic [XLEN-1:0]  imm_d [2];
  logic [TAG_W-1:0] tag_q [2];
  logic [TAG_W-1:0] tag_d [2];
  logic [1:0]       ill_q;
  logic [1:0]       ill_d;
  logic [1:0]       count_q, count_d;
  logic             wr_ptr_q, wr_ptr_d;
  logic             rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Opcode bits never contribute to any immediate.
  logic unused_opcode;
  assign unused_opcode = ^in_instr[6:0];

  always_comb begin
    dec_imm     = '0;
    dec_illegal = 1'b0;
    case (in_imm_src)
      IMM_TYPE_I:  dec_imm = XLEN'($signed(in_instr[31:20]));
      IMM_TYPE_S:  dec_imm = XLEN'($signed({in_instr[31:25], in_instr[11:7]}));
      IMM_TYPE_B:  dec_imm = XLEN'($signed({in_instr[31], in_instr[7], in_instr[30:25],
                                            in_instr[11:8], 1'b0}));
      IMM_TYPE_J:  dec_imm = XLEN'($signed({in_instr[31], in_instr[19:12], in_instr[20],
                                            in_instr[30:21], 1'b0}));
      IMM_TYPE_U:  dec_imm = XLEN'($signed({in_instr[31:12], 12'b0}));
      IMM_TYPE_Z:  dec_imm = XLEN'(in_instr[19:15]);
      IMM_TYPE_SH: begin
        if (XLEN == 64) dec_imm = XLEN'(in_instr[25:20]);
        else            dec_imm = XLEN'(in_instr[24:20]);
      end
      default:     dec_illegal = 1'b1;
    endcase
  end

  // Ready depends only on occupancy, so no path from out_ready to in_ready.
  assign in_ready    = (count_q != 2'd2);
  assign out_valid   = (count_q != 2'd0);
  assign out_imm     = imm_q[rd_ptr_q];
  assign out_tag     = tag_q[rd_ptr_q];
  assign out_illegal = ill_q[rd_ptr_q];
  assign illegal_cnt = cnt_q;

  assign accept = in_valid && in_ready;
  assign emit   = out_valid && out_ready;

  always_comb begin
    imm_d    = imm_q;
    tag_d    = tag_q;
    ill_d    = ill_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    cnt_d    = cnt_q;
    if (accept) begin
      imm_d[wr_ptr_q] = dec_imm;
      tag_d[wr_ptr_q] = in_tag;
      ill_d[wr_ptr_q] = dec_illegal;
      wr_ptr_d        = ~wr_ptr_q;
      if (dec_illegal && (cnt_q != '1)) cnt_d = cnt_q + 1'b1;
    end
    if (emit) rd_ptr_d = ~rd_ptr_q;
    case ({accept, emit})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      imm_q    <= '{default: '0};
      tag_q    <= '{default: '0};
      ill_q    <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= '0;
      cnt_q    <= '0;
    end else begin
      imm_q    <= imm_d;
      tag_q    <= tag_d;
      ill_q    <= ill_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule
